// File: rtl/fp_to_fixed_pipe_if.sv
// Start/done conversion bus of the float-to-fixed converter.
// The master drives the operands and start; the slave (converter) returns result, status and busy.
interface fp_to_fixed_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int OUT_W = 32,
    parameter int SF_W  = 6
);
    logic [EXP_W+MAN_W:0] float_in;
    logic [SF_W-1:0]      scaling_factor;
    logic [1:0]           round_mode;
    logic                 start;
    logic [OUT_W-1:0]     fixed_out;
    logic                 done;
    logic                 busy;
    logic                 overflow;
    logic                 invalid;

    modport master (
        output float_in, scaling_factor, round_mode, start,
        input  fixed_out, done, busy, overflow, invalid
    );

    modport slave (
        input  float_in, scaling_factor, round_mode, start,
        output fixed_out, done, busy, overflow, invalid
    );
endinterface

// File: rtl/fp_to_fixed_pipe.sv
// Multi-cycle IEEE-style float to two's-complement fixed-point converter with selectable
// rounding, saturation and NaN/Inf handling; one stage per FSM state, fixed 4-clock latency.
module fp_to_fixed_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int OUT_W = 32,
    parameter int SF_W  = 6
) (
    input logic clk,
    input logic rst,
    fp_to_fixed_pipe_if.slave bus
);
    localparam int FP_W   = 1 + EXP_W + MAN_W;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
    localparam int SIG_W  = MAN_W + 1;
    localparam int EXT_W  = SIG_W + MAN_W + 2;
    localparam int WIDE_W = OUT_W + SIG_W;
    localparam logic [OUT_W:0] POS_MAX = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0] NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ROUND, PACK} state_t;
    state_t state, next_state;

    logic [FP_W-1:0]  f_q;
    logic [SF_W-1:0]  sf_q;
    logic [1:0]       rm_q;
    logic             sign_q, nan_q, inf_q;
    logic [EXP_W-1:0] e_eff_q;
    logic [SIG_W-1:0] sig_q;
    logic [OUT_W-1:0] mag_q;
    logic             guard_q, sticky_q, pre_ovf_q;
    logic [OUT_W:0]   rmag_q;

    logic [EXP_W-1:0] u_exp;
    logic [MAN_W-1:0] u_man;
    int               sh;
    logic [WIDE_W-1:0] wide;
    logic [EXT_W-1:0] shr;
    logic [OUT_W-1:0] a_mag;
    logic             a_guard, a_sticky, a_pre, inc;
    logic [OUT_W:0]   r_mag;
    logic [OUT_W-1:0] p_out;
    logic             p_ovf, p_inv;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = UNPACK;
            UNPACK:  next_state = ALIGN;
            ALIGN:   next_state = ROUND;
            ROUND:   next_state = PACK;
            PACK:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign u_exp = f_q[FP_W-2:MAN_W];
    assign u_man = f_q[MAN_W-1:0];
    assign sh    = int'(e_eff_q) - BIAS - MAN_W + int'(sf_q);

    // Alignment keeps guard/sticky for right shifts; anything pushed past OUT_W flags overflow early.
    always_comb begin
        wide     = '0;
        shr      = '0;
        a_mag    = '0;
        a_guard  = 1'b0;
        a_sticky = 1'b0;
        a_pre    = 1'b0;
        if (sh >= 0) begin
            if (sh >= OUT_W) begin
                a_pre = |sig_q;
            end else begin
                wide  = WIDE_W'(sig_q) << sh;
                a_mag = wide[OUT_W-1:0];
                a_pre = |wide[WIDE_W-1:OUT_W];
            end
        end else if (-sh > MAN_W + 2) begin
            a_sticky = |sig_q;
        end else begin
            shr      = {sig_q, {(MAN_W+2){1'b0}}} >> (-sh);
            a_mag    = OUT_W'(shr[EXT_W-1:MAN_W+2]);
            a_guard  = shr[MAN_W+1];
            a_sticky = |shr[MAN_W:0];
        end
    end

    always_comb begin
        inc = 1'b0;
        case (rm_q)
            2'b00: inc = 1'b0;
            2'b01: inc = guard_q & (sticky_q | mag_q[0]);
            2'b10: inc = sign_q & (guard_q | sticky_q);
            2'b11: inc = ~sign_q & (guard_q | sticky_q);
            default: inc = 1'b0;
        endcase
        r_mag = {1'b0, mag_q} + (OUT_W+1)'(inc);
    end

    // Magnitude 2^(OUT_W-1) is still representable when the result is negative.
    always_comb begin
        p_out = '0;
        p_ovf = 1'b0;
        p_inv = 1'b0;
        if (nan_q) begin
            p_inv = 1'b1;
        end else if (inf_q || pre_ovf_q || (sign_q ? (rmag_q > NEG_LIM) : (rmag_q > POS_MAX))) begin
            p_ovf = 1'b1;
            p_out = sign_q ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            p_out = sign_q ? (~rmag_q[OUT_W-1:0] + 1'b1) : rmag_q[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            f_q       <= '0;
            sf_q      <= '0;
            rm_q      <= '0;
            sign_q    <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            e_eff_q   <= '0;
            sig_q     <= '0;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            pre_ovf_q <= 1'b0;
            rmag_q    <= '0;
            bus.fixed_out <= '0;
            bus.done      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.invalid   <= 1'b0;
        end else begin
            state    <= next_state;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    f_q  <= bus.float_in;
                    sf_q <= bus.scaling_factor;
                    rm_q <= bus.round_mode;
                end
                UNPACK: begin
                    sign_q  <= f_q[FP_W-1];
                    nan_q   <= (&u_exp) & (|u_man);
                    inf_q   <= (&u_exp) & ~(|u_man);
                    e_eff_q <= (u_exp == '0) ? EXP_W'(1) : u_exp;
                    sig_q   <= {(u_exp != '0), u_man};
                end
                ALIGN: begin
                    mag_q     <= a_mag;
                    guard_q   <= a_guard;
                    sticky_q  <= a_sticky;
                    pre_ovf_q <= a_pre;
                end
                ROUND: rmag_q <= r_mag;
                PACK: begin
                    bus.fixed_out <= p_out;
                    bus.overflow  <= p_ovf;
                    bus.invalid   <= p_inv;
                    bus.done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Randomised and directed bench for fp_to_fixed_pipe (fp16 and fp32 instances) against a
// real-arithmetic reference model.
module tb_fp_to_fixed_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fp_to_fixed_pipe_if #(.EXP_W(5), .MAN_W(10), .OUT_W(32), .SF_W(6)) bus16 ();
    fp_to_fixed_pipe_if #(.EXP_W(8), .MAN_W(23), .OUT_W(32), .SF_W(6)) bus32 ();

    fp_to_fixed_pipe #(.EXP_W(5), .MAN_W(10), .OUT_W(32), .SF_W(6)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16.slave));
    fp_to_fixed_pipe #(.EXP_W(8), .MAN_W(23), .OUT_W(32), .SF_W(6)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32.slave));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic setInputs(input bit is32, input logic [31:0] bits, input logic [5:0] sf,
                             input logic [1:0] rm, input logic st);
        if (is32) begin
            bus32.float_in = bits; bus32.scaling_factor = sf; bus32.round_mode = rm; bus32.start = st;
        end else begin
            bus16.float_in = bits[15:0]; bus16.scaling_factor = sf; bus16.round_mode = rm; bus16.start = st;
        end
    endtask

    function automatic logic getDone(input bit is32);
        return is32 ? bus32.done : bus16.done;
    endfunction
    function automatic logic getBusy(input bit is32);
        return is32 ? bus32.busy : bus16.busy;
    endfunction
    function automatic logic [31:0] getOut(input bit is32);
        return is32 ? bus32.fixed_out : bus16.fixed_out;
    endfunction
    function automatic logic [1:0] getFlags(input bit is32);
        return is32 ? {bus32.overflow, bus32.invalid} : {bus16.overflow, bus16.invalid};
    endfunction

    // Value is computed as a real number, scaled by 2^sf, rounded and then clamped to 32 bits.
    function automatic void refModel(input bit is32, input logic [31:0] bits, input int sf,
                                     input logic [1:0] rm, output logic [31:0] res,
                                     output bit ovf, output bit inv);
        int  ew, mw, expf, man, e;
        bit  s;
        real x, r, fl;
        ew   = is32 ? 8 : 5;
        mw   = is32 ? 23 : 10;
        s    = is32 ? bits[31] : bits[15];
        expf = int'((bits >> mw) & ((32'd1 << ew) - 1));
        man  = int'(bits & ((32'd1 << mw) - 1));
        res  = '0; ovf = 1'b0; inv = 1'b0;
        if (expf == (1 << ew) - 1) begin
            if (man != 0) inv = 1'b1;
            else begin
                ovf = 1'b1;
                res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            return;
        end
        e = ((expf == 0) ? 1 : expf) - ((1 << (ew - 1)) - 1) - mw + sf;
        x = ((expf == 0) ? real'(man) : real'(man + (1 << mw))) * (2.0 ** e);
        if (s) x = -x;
        case (rm)
            2'b00: r = (x >= 0.0) ? $floor(x) : $ceil(x);
            2'b10: r = $floor(x);
            2'b11: r = $ceil(x);
            default: begin
                fl = $floor(x);
                if (x - fl > 0.5) r = fl + 1.0;
                else if (x - fl < 0.5) r = fl;
                else r = ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
            end
        endcase
        if (r > 2147483647.0) begin
            ovf = 1'b1; res = 32'h7FFF_FFFF;
        end else if (r < -2147483648.0) begin
            ovf = 1'b1; res = 32'h8000_0000;
        end else begin
            res = 32'(longint'(r));
        end
    endfunction

    task automatic applyStimulus(input string tag, input bit is32, input logic [31:0] bits,
                                 input logic [5:0] sf, input logic [1:0] rm,
                                 input logic [31:0] want, input bit want_ovf, input bit want_inv);
        int cycles = 0;
        int busy_cnt = 0;
        @(negedge clk);
        setInputs(is32, bits, sf, rm, 1'b1);
        @(negedge clk);
        setInputs(is32, bits, sf, rm, 1'b0);
        while (!getDone(is32) && cycles < 20) begin
            if (getBusy(is32)) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, 64'(cycles), 64'd4);
        checkOutput({tag, " busy cycles"}, 64'(busy_cnt), 64'd4);
        checkOutput({tag, " busy at done"}, 64'(getBusy(is32)), 64'd0);
        checkOutput({tag, " out"}, 64'(getOut(is32)), 64'(want));
        checkOutput({tag, " flags"}, 64'(getFlags(is32)), 64'({want_ovf, want_inv}));
    endtask

    initial begin
        logic [31:0] exp_out, bits;
        bit          exp_ovf, exp_inv;
        int          cycles, dones;
        logic [5:0]  sf;
        logic [1:0]  rm;

        setInputs(1'b0, 32'h0, 6'd0, 2'b00, 1'b0);
        setInputs(1'b1, 32'h0, 6'd0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset out", 64'(bus16.fixed_out), 64'd0);
        checkOutput("reset done", 64'(bus16.done), 64'd0);
        checkOutput("reset busy", 64'(bus16.busy), 64'd0);
        checkOutput("reset flags", 64'(getFlags(1'b0)), 64'd0);

        applyStimulus("1.5", 1'b0, 32'h3E00, 6'd16, 2'b00, 32'h0001_8000, 1'b0, 1'b0);
        applyStimulus("-255", 1'b0, 32'hDBF8, 6'd16, 2'b00, 32'hFF01_0000, 1'b0, 1'b0);
        applyStimulus("-10.5", 1'b0, 32'hC940, 6'd16, 2'b00, 32'hFFF5_8000, 1'b0, 1'b0);
        applyStimulus("sub rtz", 1'b0, 32'h03FF, 6'd16, 2'b00, 32'd3, 1'b0, 1'b0);
        applyStimulus("sub rne", 1'b0, 32'h03FF, 6'd16, 2'b01, 32'd4, 1'b0, 1'b0);
        applyStimulus("sub floor", 1'b0, 32'h03FF, 6'd16, 2'b10, 32'd3, 1'b0, 1'b0);
        applyStimulus("sub ceil", 1'b0, 32'h03FF, 6'd16, 2'b11, 32'd4, 1'b0, 1'b0);
        applyStimulus("nsub rtz", 1'b0, 32'h83FF, 6'd16, 2'b00, 32'hFFFF_FFFD, 1'b0, 1'b0);
        applyStimulus("nsub rne", 1'b0, 32'h83FF, 6'd16, 2'b01, 32'hFFFF_FFFC, 1'b0, 1'b0);
        applyStimulus("nsub floor", 1'b0, 32'h83FF, 6'd16, 2'b10, 32'hFFFF_FFFC, 1'b0, 1'b0);
        applyStimulus("nsub ceil", 1'b0, 32'h83FF, 6'd16, 2'b11, 32'hFFFF_FFFD, 1'b0, 1'b0);
        applyStimulus("max", 1'b0, 32'h7BFF, 6'd16, 2'b00, 32'h7FFF_FFFF, 1'b1, 1'b0);
        applyStimulus("-inf", 1'b0, 32'hFC00, 6'd16, 2'b00, 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus("nan", 1'b0, 32'h7E00, 6'd16, 2'b00, 32'h0, 1'b0, 1'b1);
        applyStimulus("-0", 1'b0, 32'h8000, 6'd16, 2'b00, 32'h0, 1'b0, 1'b0);
        applyStimulus("neg min exact", 1'b0, 32'hF800, 6'd16, 2'b00, 32'h8000_0000, 1'b0, 1'b0);
        applyStimulus("fp32 1.5", 1'b1, 32'h3FC0_0000, 6'd16, 2'b00, 32'h0001_8000, 1'b0, 1'b0);
        applyStimulus("fp32 2^31", 1'b1, 32'h4F00_0000, 6'd16, 2'b00, 32'h7FFF_FFFF, 1'b1, 1'b0);
        applyStimulus("fp32 rne", 1'b1, 32'h3F80_0001, 6'd0, 2'b01, 32'd1, 1'b0, 1'b0);

        // Second start two cycles into a conversion must be ignored.
        @(negedge clk);
        setInputs(1'b0, 32'h3E00, 6'd16, 2'b00, 1'b1);
        @(negedge clk);
        setInputs(1'b0, 32'h3E00, 6'd16, 2'b00, 1'b0);
        @(negedge clk);
        setInputs(1'b0, 32'h7BFF, 6'd16, 2'b00, 1'b1);
        @(negedge clk);
        setInputs(1'b0, 32'h7BFF, 6'd16, 2'b00, 1'b0);
        cycles = 2;
        while (!bus16.done && cycles < 20) begin @(negedge clk); cycles++; end
        checkOutput("ignore latency", 64'(cycles), 64'd4);
        checkOutput("ignore out", 64'(bus16.fixed_out), 64'h0001_8000);
        checkOutput("ignore flags", 64'(getFlags(1'b0)), 64'd0);
        dones = 0;
        repeat (8) begin @(negedge clk); if (bus16.done) dones++; end
        checkOutput("ignore extra done", 64'(dones), 64'd0);

        // Start raised in the done cycle runs back to back.
        @(negedge clk);
        setInputs(1'b0, 32'h3E00, 6'd16, 2'b00, 1'b1);
        @(negedge clk);
        setInputs(1'b0, 32'h3E00, 6'd16, 2'b00, 1'b0);
        cycles = 0;
        while (!bus16.done && cycles < 20) begin @(negedge clk); cycles++; end
        checkOutput("b2b first out", 64'(bus16.fixed_out), 64'h0001_8000);
        setInputs(1'b0, 32'hC940, 6'd16, 2'b00, 1'b1);
        @(negedge clk);
        setInputs(1'b0, 32'hC940, 6'd16, 2'b00, 1'b0);
        cycles = 1;
        while (!bus16.done && cycles < 20) begin @(negedge clk); cycles++; end
        checkOutput("b2b spacing", 64'(cycles), 64'd5);
        checkOutput("b2b second out", 64'(bus16.fixed_out), 64'hFFF5_8000);

        // Reset during ALIGN discards the conversion.
        @(negedge clk);
        setInputs(1'b0, 32'h3E00, 6'd16, 2'b00, 1'b1);
        @(negedge clk);
        setInputs(1'b0, 32'h3E00, 6'd16, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (6) begin if (bus16.done) dones++; @(negedge clk); end
        checkOutput("rst no done", 64'(dones), 64'd0);
        checkOutput("rst out", 64'(bus16.fixed_out), 64'd0);
        checkOutput("rst busy", 64'(bus16.busy), 64'd0);
        applyStimulus("after rst", 1'b0, 32'h3E00, 6'd16, 2'b00, 32'h0001_8000, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            bits = 32'($urandom_range(0, 16'hFFFF));
            sf   = 6'($urandom_range(0, 40));
            rm   = 2'($urandom_range(0, 3));
            refModel(1'b0, bits, int'(sf), rm, exp_out, exp_ovf, exp_inv);
            applyStimulus($sformatf("rnd16 %h sf%0d rm%0d", bits[15:0], sf, rm), 1'b0, bits, sf, rm,
                          exp_out, exp_ovf, exp_inv);
        end
        for (int i = 0; i < 60; i++) begin
            bits = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 160)), 23'($urandom)};
            if (i % 10 == 0) bits[30:23] = 8'($urandom_range(0, 1) ? 8'hFF : 8'h00);
            sf   = 6'($urandom_range(0, 63));
            rm   = 2'($urandom_range(0, 3));
            refModel(1'b1, bits, int'(sf), rm, exp_out, exp_ovf, exp_inv);
            applyStimulus($sformatf("rnd32 %h sf%0d rm%0d", bits, sf, rm), 1'b1, bits, sf, rm,
                          exp_out, exp_ovf, exp_inv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
